// File: rtl/bsg_link_upstream_arbiter.sv
// bsg_link_upstream_arbiter
//   Shares the core-side port of a bsg_link_ddr_upstream among NUM_REQ
//   requesters. Round-robin arbitration feeds a single registered output
//   stage. Issue is gated by a token-credit counter so no word is sent unless
//   the downstream buffer has room. Lives in the core clock domain.
//
// Ports
//   clk, rst       core clock, asynchronous active-high reset
//   req_valid_i    per-requester valid
//   req_data_i     requester i drives slice [i*WIDTH +: WIDTH]
//   req_ready_o    one-hot accept strobe
//   link_valid_o   to link core_valid_i (registered)
//   link_data_o    to link core_data_i (registered)
//   link_ready_i   from link core_ready_o
//   token_i        synchronized token pulse, returns TOKEN_DECIMATION credits
//   credit_o       current credit count
//   grant_id_o     requester index of the word in the output register
//   stall_o        a request is pending while credit_o==0
//   err_o          sticky credit-overflow flag
//   stat_cnt_o     per-requester 16-bit transfer counters
//
// Optional feature
//   BSG_UPSTREAM_ARB_STATS_EN: when defined, stat_cnt_o carries live wrapping
//   transfer counters; otherwise it is tied to zero and no counter flops exist.

module bsg_link_upstream_arbiter #(
  parameter int unsigned NUM_REQ          = 4,
  parameter int unsigned WIDTH            = 64,
  parameter int unsigned CREDITS          = 32,
  parameter int unsigned TOKEN_DECIMATION = 8,
  localparam int unsigned CNT_W           = $clog2(CREDITS + 1),
  localparam int unsigned ID_W            = $clog2(NUM_REQ)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req_valid_i,
  input  logic [NUM_REQ*WIDTH-1:0] req_data_i,
  output logic [NUM_REQ-1:0]       req_ready_o,
  output logic                     link_valid_o,
  output logic [WIDTH-1:0]         link_data_o,
  input  logic                     link_ready_i,
  input  logic                     token_i,
  output logic [CNT_W-1:0]         credit_o,
  output logic [ID_W-1:0]          grant_id_o,
  output logic                     stall_o,
  output logic                     err_o,
  output logic [NUM_REQ*16-1:0]    stat_cnt_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY  = 2'd1,
    STALL = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  credit_q, credit_d;
  logic              err_q, err_d;
  logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [WIDTH-1:0]  data_q, data_d;
  logic [ID_W-1:0]   gid_q, gid_d;

  logic              any_req;
  logic              credit_zero;
  logic              load;
  logic [ID_W-1:0]   grant;
  logic [31:0]       credit_sum;

  assign any_req     = |req_valid_i;
  assign credit_zero = (credit_q == '0);

  // Output register is full exactly when in BUSY, so link_valid_o is a pure
  // function of registered state.
  assign link_valid_o = (state_q == BUSY);
  assign load         = (~link_valid_o | link_ready_i) & ~credit_zero & any_req;

  // Round-robin search starting at the pointer and wrapping.
  always_comb begin
    logic        found;
    int unsigned idx;
    grant = '0;
    found = 1'b0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      idx = (32'(rr_ptr_q) + k) % NUM_REQ;
      if (!found && req_valid_i[idx]) begin
        found = 1'b1;
        grant = ID_W'(idx);
      end
    end
  end

  always_comb begin
    req_ready_o = '0;
    if (load) req_ready_o[grant] = 1'b1;
  end

  // Datapath next-state: output register, pointer, credits.
  always_comb begin
    data_d   = data_q;
    gid_d    = gid_q;
    rr_ptr_d = rr_ptr_q;
    err_d    = err_q;
    if (load) begin
      data_d   = req_data_i[32'(grant)*WIDTH +: WIDTH];
      gid_d    = grant;
      rr_ptr_d = ID_W'((32'(grant) + 32'd1) % NUM_REQ);
    end
    // Credit is reserved at load; load never happens at zero, so no underflow.
    credit_sum = 32'(credit_q) - 32'(load) + (token_i ? 32'(TOKEN_DECIMATION) : 32'd0);
    if (credit_sum > 32'(CREDITS)) begin
      credit_d = CNT_W'(CREDITS);
      err_d    = 1'b1;
    end else begin
      credit_d = CNT_W'(credit_sum);
    end
  end

  // FSM next-state.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (load)                       state_d = BUSY;
        else if (any_req && credit_zero) state_d = STALL;
      end
      BUSY: begin
        if (link_ready_i) begin
          if (load)                        state_d = BUSY;
          else if (any_req && credit_zero) state_d = STALL;
          else                             state_d = IDLE;
        end
      end
      STALL: begin
        if (load)          state_d = BUSY;
        else if (!any_req) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      credit_q <= CNT_W'(CREDITS);
      err_q    <= 1'b0;
      rr_ptr_q <= '0;
      data_q   <= '0;
      gid_q    <= '0;
    end else begin
      state_q  <= state_d;
      credit_q <= credit_d;
      err_q    <= err_d;
      rr_ptr_q <= rr_ptr_d;
      data_q   <= data_d;
      gid_q    <= gid_d;
    end
  end

  assign link_data_o = data_q;
  assign grant_id_o  = gid_q;
  assign credit_o    = credit_q;
  assign err_o       = err_q;
  assign stall_o     = credit_zero & any_req;

`ifdef BSG_UPSTREAM_ARB_STATS_EN
  logic [NUM_REQ*16-1:0] stat_q, stat_d;

  always_comb begin
    stat_d = stat_q;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      if (req_ready_o[k] & req_valid_i[k])
        stat_d[k*16 +: 16] = stat_q[k*16 +: 16] + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) stat_q <= '0;
    else     stat_q <= stat_d;
  end

  assign stat_cnt_o = stat_q;
`else
  assign stat_cnt_o = '0;
`endif

endmodule

// File: tb/tb_bsg_link_upstream_arbiter.sv
// Testbench for bsg_link_upstream_arbiter (default parameters: 4 x 64-bit,
// 32 credits, 8 credits per token). Expected link words are queued when the
// stimulus is set up; a monitor pops and compares on every link handshake.

module tb_bsg_link_upstream_arbiter;

  localparam int NUM_REQ = 4;
  localparam int WIDTH   = 64;

  logic                     clk;
  logic                     rst;
  logic [NUM_REQ-1:0]       req_valid_i;
  logic [NUM_REQ*WIDTH-1:0] req_data_i;
  logic [NUM_REQ-1:0]       req_ready_o;
  logic                     link_valid_o;
  logic [WIDTH-1:0]         link_data_o;
  logic                     link_ready_i;
  logic                     token_i;
  logic [5:0]               credit_o;
  logic [1:0]               grant_id_o;
  logic                     stall_o;
  logic                     err_o;
  logic [NUM_REQ*16-1:0]    stat_cnt_o;

  bsg_link_upstream_arbiter #(
    .NUM_REQ(4), .WIDTH(64), .CREDITS(32), .TOKEN_DECIMATION(8)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid_i(req_valid_i), .req_data_i(req_data_i), .req_ready_o(req_ready_o),
    .link_valid_o(link_valid_o), .link_data_o(link_data_o), .link_ready_i(link_ready_i),
    .token_i(token_i), .credit_o(credit_o), .grant_id_o(grant_id_o),
    .stall_o(stall_o), .err_o(err_o), .stat_cnt_o(stat_cnt_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  id;
    logic [63:0] data;
  } exp_t;

  exp_t exp_q[$];
  int   exp_seq[NUM_REQ];
  int   drv_seq[NUM_REQ];
  int   n_cmp = 0;
  int   n_err = 0;

  function automatic logic [63:0] mk(int i, int n);
    logic [7:0] t;
    t = 8'(8'hA0 + i);
    return {t, 24'h5A5A5A, 32'(n)};
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic push_expect(input int id, output logic [63:0] d);
    exp_t e;
    e.id   = 2'(id);
    e.data = mk(id, exp_seq[id]);
    d      = e.data;
    exp_seq[id]++;
    exp_q.push_back(e);
  endtask

  task automatic push_rr(input int first, input int count);
    logic [63:0] d;
    for (int k = 0; k < count; k++) push_expect((first + k) % NUM_REQ, d);
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_credit(input int target, input int bound, input string nm);
    int k;
    k = 0;
    while (int'(credit_o) != target && k < bound) begin
      tick();
      k++;
    end
    chk(nm, 64'(credit_o), 64'(target));
  endtask

  // Requester model: each accepted requester presents its next word.
  initial begin
    for (int i = 0; i < NUM_REQ; i++) begin
      drv_seq[i] = 0;
      exp_seq[i] = 0;
      req_data_i[i*WIDTH +: WIDTH] = mk(i, 0);
    end
    forever begin
      logic [NUM_REQ-1:0] acc;
      @(negedge clk);
      acc = req_ready_o & req_valid_i;
      @(posedge clk);
      #1;
      for (int i = 0; i < NUM_REQ; i++) begin
        if (acc[i]) begin
          drv_seq[i]++;
          req_data_i[i*WIDTH +: WIDTH] = mk(i, drv_seq[i]);
        end
      end
    end
  end

  // Monitor: compare every link handshake against the expected queue.
  initial begin
    forever begin
      exp_t e;
      @(negedge clk);
      if (!rst && link_valid_o && link_ready_i) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_word: got id %0d data %0h expected none at %0t",
                   grant_id_o, link_data_o, $time);
        end else begin
          e = exp_q.pop_front();
          chk("tx_id", 64'(grant_id_o), 64'(e.id));
          chk("tx_data", link_data_o, e.data);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    logic [63:0] d0;
    logic [63:0] stat_exp;

    rst          = 1'b1;
    req_valid_i  = '0;
    link_ready_i = 1'b0;
    token_i      = 1'b0;
    tick();
    chk("rst_valid",  64'(link_valid_o), 64'd0);
    chk("rst_data",   link_data_o, 64'd0);
    chk("rst_gid",    64'(grant_id_o), 64'd0);
    chk("rst_credit", 64'(credit_o), 64'd32);
    chk("rst_err",    64'(err_o), 64'd0);
    chk("rst_stat",   stat_cnt_o, 64'd0);
    tick();
    rst = 1'b0;
    tick();

    // 1: all requesters, exhaust 32 credits in round-robin order
    push_rr(0, 32);
    req_valid_i  = 4'hF;
    link_ready_i = 1'b1;
    wait_credit(0, 60, "t1_credit0");
    chk("t1_stall", 64'(stall_o), 64'd1);
    chk("t1_ready", 64'(req_ready_o), 64'd0);
    tick();
    tick();
    chk("t1_drained", 64'(exp_q.size()), 64'd0);

    // 2: one token releases exactly 8 words
    push_rr(0, 8);
    token_i = 1'b1;
    tick();
    token_i = 1'b0;
    chk("t2_credit8", 64'(credit_o), 64'd8);
    chk("t2_nostall", 64'(stall_o), 64'd0);
    wait_credit(0, 20, "t2_credit0");
    chk("t2_stall", 64'(stall_o), 64'd1);
    tick();
    tick();
    chk("t2_drained", 64'(exp_q.size()), 64'd0);

    // 3: link backpressure holds the output register
    link_ready_i = 1'b0;
    push_expect(0, d0);
    push_rr(1, 7);
    token_i = 1'b1;
    tick();
    token_i = 1'b0;
    tick();
    chk("t3_valid",  64'(link_valid_o), 64'd1);
    chk("t3_gid",    64'(grant_id_o), 64'd0);
    chk("t3_data",   link_data_o, d0);
    chk("t3_credit", 64'(credit_o), 64'd7);
    for (int c = 0; c < 5; c++) begin
      tick();
      chk("t3_hold_data",   link_data_o, d0);
      chk("t3_hold_gid",    64'(grant_id_o), 64'd0);
      chk("t3_hold_ready",  64'(req_ready_o), 64'd0);
      chk("t3_hold_credit", 64'(credit_o), 64'd7);
    end
    link_ready_i = 1'b1;
    wait_credit(0, 20, "t3_credit0");
    tick();
    tick();
    chk("t3_drained", 64'(exp_q.size()), 64'd0);

    // 4: load and token in the same cycle at credit 5
    push_rr(0, 16);
    token_i = 1'b1;
    tick();
    token_i = 1'b0;
    wait_credit(5, 20, "t4_credit5");
    token_i = 1'b1;
    tick();
    token_i = 1'b0;
    chk("t4_credit12", 64'(credit_o), 64'd12);
    wait_credit(0, 30, "t4_credit0");
    tick();
    tick();
    chk("t4_drained", 64'(exp_q.size()), 64'd0);

    // 5: credit overflow saturates and sets a sticky error
    req_valid_i = '0;
    token_i = 1'b1;
    repeat (4) tick();
    token_i = 1'b0;
    chk("t5_credit32", 64'(credit_o), 64'd32);
    chk("t5_noerr",    64'(err_o), 64'd0);
    push_rr(2, 1);
    push_rr(2, 1);
    req_valid_i = 4'b0100;
    tick();
    tick();
    req_valid_i = '0;
    chk("t5_credit30", 64'(credit_o), 64'd30);
    token_i = 1'b1;
    tick();
    token_i = 1'b0;
    chk("t5_sat",  64'(credit_o), 64'd32);
    chk("t5_err",  64'(err_o), 64'd1);
    repeat (3) tick();
    chk("t5_err_sticky", 64'(err_o), 64'd1);
    chk("t5_drained", 64'(exp_q.size()), 64'd0);

    // 6: asynchronous reset while BUSY
    link_ready_i = 1'b0;
    req_valid_i  = 4'hF;
    push_expect(3, d0);
    tick();
    chk("t6_gid3",  64'(grant_id_o), 64'd3);
    chk("t6_busy",  64'(link_valid_o), 64'd1);
    tick();
    rst = 1'b1;
    #1;
    chk("t6_rst_valid",  64'(link_valid_o), 64'd0);
    chk("t6_rst_credit", 64'(credit_o), 64'd32);
    chk("t6_rst_err",    64'(err_o), 64'd0);
    chk("t6_rst_gid",    64'(grant_id_o), 64'd0);
    exp_q.delete();
    #1;
    rst = 1'b0;
    push_expect(0, d0);
    tick();
    chk("t6_first_gid", 64'(grant_id_o), 64'd0);
    chk("t6_first_data", link_data_o, d0);
    req_valid_i  = '0;
    link_ready_i = 1'b1;
    tick();
    tick();
    chk("t6_drained", 64'(exp_q.size()), 64'd0);

    // 7: per-requester statistics
    rst = 1'b1;
    #1;
    rst = 1'b0;
    chk("t7_stat_rst", stat_cnt_o, 64'd0);
    push_rr(2, 1);
    push_rr(2, 1);
    for (int k = 0; k < 8; k++) push_rr(2, 1);
    req_valid_i = 4'b0100;
    repeat (10) tick();
    req_valid_i = '0;
    tick();
    tick();
    chk("t7_credit", 64'(credit_o), 64'd22);
`ifdef BSG_UPSTREAM_ARB_STATS_EN
    stat_exp = 64'h0000_000A_0000_0000;
`else
    stat_exp = 64'd0;
`endif
    chk("t7_stat", stat_cnt_o, stat_exp);
    chk("t7_drained", 64'(exp_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
